// File: rtl/memory_stage.sv
// MEM pipeline stage: waits on data-SRAM responses, aligns load data, feeds writeback and bypass.
// LWL/LWR merge logic is built only when MS_LWLR_EN is defined.
package memory_stage_pkg;
  typedef struct packed {
    logic       ex;
    logic [4:0] excode;
  } exception_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic [2:0]  load_op;
    logic        mem_req;
    logic [31:0] rt_value;
    exception_t  exception;
    logic [1:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [1:0]  tlb_op;
    logic [4:0]  cache_op;
    logic [31:0] phy_addr;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    exception_t  exception;
    logic [1:0]  c0_op;
    logic [7:0]  c0_addr;
    logic [1:0]  tlb_op;
    logic [4:0]  cache_op;
    logic [31:0] phy_addr;
  } ms_to_ws_bus_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          es_to_valid,
  output logic          ms_allowin,
  input  es_to_ms_bus_t es_to_ms_bus,
  output logic          ms_to_valid,
  input  logic          ws_allowin,
  output ms_to_ws_bus_t ms_to_ws_bus,
  input  logic          pipeline_flush,
  input  logic          data_data_ok,
  input  logic [31:0]   data_rdata,
  output logic [4:0]    ms_fwd_dest,
  output logic [31:0]   ms_fwd_result,
  output logic          ms_fwd_stall
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_CANCEL} state_e;

  state_e        state_q, state_d;
  logic          ms_valid_q, ms_valid_d;
  es_to_ms_bus_t bus_q, bus_d;
  logic [31:0]   rdata_buf_q, rdata_buf_d;

  logic        ms_ready_go;
  logic        accept;
  logic [31:0] raw;
  logic [1:0]  offset;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_result;

  assign ms_ready_go = !bus_q.mem_req || (state_q == S_WAIT && data_data_ok) || state_q == S_HOLD;
  assign ms_allowin  = (!ms_valid_q || (ms_ready_go && ws_allowin)) && state_q != S_CANCEL;
  assign ms_to_valid = ms_valid_q && ms_ready_go && !pipeline_flush;
  assign accept      = es_to_valid && ms_allowin && !pipeline_flush;

  // A response still owed to a flushed instruction parks the stage in CANCEL until it drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (data_data_ok)        state_d = (ws_allowin || pipeline_flush) ? S_IDLE : S_HOLD;
        else if (pipeline_flush) state_d = S_CANCEL;
      end
      S_HOLD:   if (ws_allowin || pipeline_flush) state_d = S_IDLE;
      S_CANCEL: if (data_data_ok) state_d = S_IDLE;
      default:  ;
    endcase
    if (accept && es_to_ms_bus.mem_req) state_d = S_WAIT;
  end

  always_comb begin
    ms_valid_d = ms_valid_q;
    if (pipeline_flush)  ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_valid;
    bus_d       = accept ? es_to_ms_bus : bus_q;
    rdata_buf_d = rdata_buf_q;
    if (state_q == S_WAIT && data_data_ok && !ws_allowin && !pipeline_flush)
      rdata_buf_d = data_rdata;
  end

  assign raw     = (state_q == S_HOLD) ? rdata_buf_q : data_rdata;
  assign offset  = bus_q.result[1:0];
  assign ld_half = offset[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    case (offset)
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      default: ld_byte = raw[31:24];
    endcase
  end

`ifdef MS_LWLR_EN
  logic [31:0] rt;
  logic [31:0] lwl_data, lwr_data;
  assign rt = bus_q.rt_value;

  always_comb begin
    case (offset)
      2'd0:    begin lwl_data = {raw[7:0],  rt[23:0]}; lwr_data = raw;                       end
      2'd1:    begin lwl_data = {raw[15:0], rt[15:0]}; lwr_data = {rt[31:24], raw[31:8]};  end
      2'd2:    begin lwl_data = {raw[23:0], rt[7:0]};  lwr_data = {rt[31:16], raw[31:16]}; end
      default: begin lwl_data = raw;                   lwr_data = {rt[31:8],  raw[31:24]}; end
    endcase
  end
`else
  logic [31:0] lwl_data, lwr_data;
  logic        unused_rt;
  assign lwl_data  = raw;
  assign lwr_data  = raw;
  assign unused_rt = ^bus_q.rt_value;
`endif

  always_comb begin
    case (bus_q.load_op)
      3'd1:    final_result = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    final_result = {24'h0, ld_byte};
      3'd3:    final_result = {{16{ld_half[15]}}, ld_half};
      3'd4:    final_result = {16'h0, ld_half};
      3'd5:    final_result = raw;
      3'd6:    final_result = lwl_data;
      3'd7:    final_result = lwr_data;
      default: final_result = bus_q.result;
    endcase
  end

  always_comb begin
    ms_to_ws_bus.pc        = bus_q.pc;
    ms_to_ws_bus.dest      = bus_q.dest;
    ms_to_ws_bus.rf_we     = bus_q.rf_we;
    ms_to_ws_bus.result    = final_result;
    ms_to_ws_bus.exception = bus_q.exception;
    ms_to_ws_bus.c0_op     = bus_q.c0_op;
    ms_to_ws_bus.c0_addr   = bus_q.c0_addr;
    ms_to_ws_bus.tlb_op    = bus_q.tlb_op;
    ms_to_ws_bus.cache_op  = bus_q.cache_op;
    ms_to_ws_bus.phy_addr  = bus_q.phy_addr;
  end

  assign ms_fwd_dest   = ms_valid_q ? bus_q.dest : 5'd0;
  assign ms_fwd_result = final_result;
  assign ms_fwd_stall  = ms_valid_q && (bus_q.load_op != 3'd0) && !ms_ready_go;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      rdata_buf_q <= '0;
    end else begin
      state_q     <= state_d;
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          es_to_valid;
  logic          ms_allowin;
  es_to_ms_bus_t es_to_ms_bus;
  logic          ms_to_valid;
  logic          ws_allowin;
  ms_to_ws_bus_t ms_to_ws_bus;
  logic          pipeline_flush;
  logic          data_data_ok;
  logic [31:0]   data_rdata;
  logic [4:0]    ms_fwd_dest;
  logic [31:0]   ms_fwd_result;
  logic          ms_fwd_stall;

  memory_stage dut (
    .clk(clk), .reset(reset), .es_to_valid(es_to_valid), .ms_allowin(ms_allowin),
    .es_to_ms_bus(es_to_ms_bus), .ms_to_valid(ms_to_valid), .ws_allowin(ws_allowin),
    .ms_to_ws_bus(ms_to_ws_bus), .pipeline_flush(pipeline_flush), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result),
    .ms_fwd_stall(ms_fwd_stall)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: the single instruction resident in MEM and what is owed/buffered for it.
  logic          m_valid, m_owe, m_dead, m_have;
  es_to_ms_bus_t m_ins;
  logic [31:0]   m_buf;
  logic          t_allow, t_tv;
  int unsigned   resp_wait;

  function automatic logic [31:0] ref_result(input es_to_ms_bus_t i, input logic [31:0] raw);
    int unsigned sh, hs, shl;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ones;
    sh   = 8 * int'(i.result[1:0]);
    hs   = i.result[1] ? 16 : 0;
    shl  = 24 - sh;
    b    = 8'(raw >> sh);
    h    = 16'(raw >> hs);
    ones = '1;
    case (i.load_op)
      3'd1: return 32'($signed(b));
      3'd2: return 32'(b);
      3'd3: return 32'($signed(h));
      3'd4: return 32'(h);
      3'd5: return raw;
`ifdef MS_LWLR_EN
      3'd6: return (raw << shl) | (i.rt_value & ((32'h1 << shl) - 32'h1));
      3'd7: return (raw >> sh) | (i.rt_value & ~(ones >> sh));
`else
      3'd6: return raw;
      3'd7: return raw;
`endif
      default: return i.result;
    endcase
  endfunction

  function automatic es_to_ms_bus_t mk(input logic [2:0] op, input logic req, input logic [31:0] res,
                                       input logic [31:0] rt, input logic [4:0] dest);
    es_to_ms_bus_t i;
    i          = '0;
    i.pc       = 32'hBFC0_0000 + {27'h0, dest};
    i.dest     = dest;
    i.rf_we    = 4'hF;
    i.result   = res;
    i.load_op  = op;
    i.mem_req  = req;
    i.rt_value = rt;
    return i;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_owe = 0; m_dead = 0; m_have = 0; m_buf = '0; m_ins = '0; resp_wait = 0;
  endtask

  task automatic drive(input logic ev, input es_to_ms_bus_t ins, input logic wa, input logic fl,
                       input logic dok, input logic [31:0] rd);
    logic        ready;
    logic [31:0] raw;
    @(negedge clk);
    es_to_valid = ev; es_to_ms_bus = ins; ws_allowin = wa; pipeline_flush = fl;
    data_data_ok = dok; data_rdata = rd;
    #1;
    ready   = !m_ins.mem_req || m_have || (m_owe && dok);
    t_allow = (!m_valid || (ready && wa)) && !m_dead;
    t_tv    = m_valid && ready && !fl;
    raw     = m_have ? m_buf : rd;
    check("allowin", ms_allowin, t_allow);
    check("to_valid", ms_to_valid, t_tv);
    check("fwd_dest", ms_fwd_dest, m_valid ? m_ins.dest : 5'd0);
    check("fwd_stall", ms_fwd_stall, m_valid && m_ins.load_op != 3'd0 && !ready);
    if (t_tv) begin
      check("wb_result", ms_to_ws_bus.result, ref_result(m_ins, raw));
      check("wb_pc", ms_to_ws_bus.pc, m_ins.pc);
      check("wb_dest", ms_to_ws_bus.dest, m_ins.dest);
      check("wb_rf_we", ms_to_ws_bus.rf_we, m_ins.rf_we);
      check("wb_ex", ms_to_ws_bus.exception.ex, m_ins.exception.ex);
    end
    if (m_valid && ready) check("fwd_result", ms_fwd_result, ref_result(m_ins, raw));
  endtask

  task automatic tick();
    logic handoff, accept;
    @(posedge clk);
    handoff = t_tv && ws_allowin;
    accept  = es_to_valid && t_allow && !pipeline_flush;
    if (data_data_ok) begin
      if (m_dead) m_dead = 0;
      else if (m_owe) begin
        m_owe = 0;
        if (!pipeline_flush && !handoff) begin m_have = 1; m_buf = data_rdata; end
      end
    end
    if (pipeline_flush) begin
      if (m_owe) begin m_dead = 1; m_owe = 0; end
      m_valid = 0; m_have = 0;
    end else if (handoff) begin
      m_valid = 0; m_have = 0;
    end
    if (accept) begin
      m_valid = 1; m_ins = es_to_ms_bus; m_owe = es_to_ms_bus.mem_req;
      if (es_to_ms_bus.mem_req) resp_wait = $urandom_range(1, 4);
    end
  endtask

  es_to_ms_bus_t nop;

  initial begin
    nop = '0;
    reset = 1; es_to_valid = 0; es_to_ms_bus = '0; ws_allowin = 0; pipeline_flush = 0;
    data_data_ok = 0; data_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_to_valid", ms_to_valid, 1'b0);
    check("rst_allowin", ms_allowin, 1'b1);
    check("rst_fwd_dest", ms_fwd_dest, 5'd0);
    check("rst_fwd_stall", ms_fwd_stall, 1'b0);
    @(negedge clk) reset = 0;

    // Non-memory instruction passes in one cycle.
    drive(1, mk(3'd0, 0, 32'h1234_5678, 32'h0, 5'd5), 1, 0, 0, '0); tick();
    drive(0, nop, 1, 0, 0, '0);
    check("add_result", ms_to_ws_bus.result, 32'h1234_5678);
    check("add_to_valid", ms_to_valid, 1'b1);
    tick();

    // LB / LBU at offset 3 with a two-cycle response delay.
    for (int k = 0; k < 2; k++) begin
      drive(1, mk(k == 0 ? 3'd1 : 3'd2, 1, 32'h0000_1003, 32'h0, 5'd7), 1, 0, 0, '0); tick();
      drive(0, nop, 1, 0, 0, '0); check("lb_stall1", ms_fwd_stall, 1'b1); tick();
      drive(0, nop, 1, 0, 0, '0); check("lb_stall2", ms_fwd_stall, 1'b1); tick();
      drive(0, nop, 1, 0, 1, 32'h80FF_0000);
      check("lb_result", ms_to_ws_bus.result, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
      tick();
    end

    // LW response arrives while writeback stalls: buffered, then delivered.
    drive(1, mk(3'd5, 1, 32'h0000_2000, 32'h0, 5'd9), 1, 0, 0, '0); tick();
    drive(0, nop, 0, 0, 1, 32'hDEAD_BEEF); tick();
    drive(0, nop, 0, 0, 0, 32'h0); check("hold_allowin", ms_allowin, 1'b0); tick();
    drive(0, nop, 0, 0, 0, 32'h0); tick();
    drive(0, nop, 1, 0, 0, 32'h0);
    check("hold_result", ms_to_ws_bus.result, 32'hDEAD_BEEF);
    check("hold_to_valid", ms_to_valid, 1'b1);
    tick();

    // Flush while waiting: orphaned response is dropped.
    drive(1, mk(3'd5, 1, 32'h0000_3000, 32'h0, 5'd3), 1, 0, 0, '0); tick();
    drive(0, nop, 1, 1, 0, '0); tick();
    drive(1, mk(3'd0, 0, 32'h5, 32'h0, 5'd4), 1, 0, 0, '0);
    check("cancel_allowin", ms_allowin, 1'b0); tick();
    drive(1, mk(3'd0, 0, 32'h5, 32'h0, 5'd4), 1, 0, 1, 32'h1);
    check("cancel_to_valid", ms_to_valid, 1'b0); tick();
    drive(0, nop, 1, 0, 0, '0); check("cancel_idle", ms_allowin, 1'b1); tick();

    // LWL at offset 1.
    drive(1, mk(3'd6, 1, 32'h0000_4001, 32'hAABB_CCDD, 5'd6), 1, 0, 0, '0); tick();
    drive(0, nop, 1, 0, 1, 32'h4433_2211);
`ifdef MS_LWLR_EN
    check("lwl_result", ms_to_ws_bus.result, 32'h2211_CCDD);
`else
    check("lwl_result", ms_to_ws_bus.result, 32'h4433_2211);
`endif
    check("lwl_rf_we", ms_to_ws_bus.rf_we, 4'hF);
    tick();

    // Asynchronous reset in the middle of a wait.
    drive(1, mk(3'd5, 1, 32'h0000_5000, 32'h0, 5'd8), 1, 0, 0, '0); tick();
    drive(0, nop, 1, 0, 0, '0);
    reset = 1; #1;
    check("arst_to_valid", ms_to_valid, 1'b0);
    check("arst_allowin", ms_allowin, 1'b1);
    check("arst_stall", ms_fwd_stall, 1'b0);
    model_reset();
    @(posedge clk); #1 reset = 0;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      es_to_ms_bus_t ins;
      logic dok;
      logic [2:0] op;
      dok = 0;
      if (resp_wait > 0) begin resp_wait--; dok = (resp_wait == 0); end
      ins          = '0;
      ins.pc       = $urandom;
      ins.dest     = 5'($urandom_range(0, 31));
      ins.rf_we    = 4'($urandom);
      ins.result   = $urandom;
      ins.rt_value = $urandom;
      ins.c0_op    = 2'($urandom);
      ins.c0_addr  = 8'($urandom);
      ins.tlb_op   = 2'($urandom);
      ins.cache_op = 5'($urandom);
      ins.phy_addr = $urandom;
      op           = 3'($urandom_range(0, 7));
      if (resp_wait == 0 && (op != 3'd0 || $urandom_range(0, 3) == 0)) begin
        ins.load_op = op; ins.mem_req = 1;
      end else begin
        ins.exception.ex     = ($urandom_range(0, 15) == 0);
        ins.exception.excode = 5'($urandom);
      end
      drive($urandom_range(0, 9) < 7, ins, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0, dok, $urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
